// File: rtl/ex_muldiv.sv
// ex_muldiv: iterative RV32M multiply/divide unit for the EX stage.
// Ports: clk, rst, start/op/rs1_data/rs2_data/rd_addr, flush -> busy, result_valid, result, result_rd.
module ex_muldiv #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [4:0]      rd_addr,
  input  logic            flush,
  output logic            busy,
  output logic            result_valid,
  output logic [XLEN-1:0] result,
  output logic [4:0]      result_rd
);

  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0] LAST = CW'(XLEN - 1);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t            state;
  logic [CW-1:0]     cnt;
  logic [2:0]        op_q;
  logic [4:0]        rd_q;
  logic [XLEN-1:0]   a_mag;
  logic [XLEN-1:0]   b_mag;
  logic [2*XLEN-1:0] p;
  logic              neg_q;
  logic              rneg_q;

  // operand decode at accept
  logic            a_sgn, b_sgn, a_neg, b_neg;
  logic [XLEN-1:0] a_abs, b_abs;
  logic            div0, ovf;
  logic [XLEN-1:0] spec_res;

  assign a_sgn = (op == 3'b001) | (op == 3'b010) |
                 (op == 3'b100) | (op == 3'b110);
  assign b_sgn = (op == 3'b001) | (op == 3'b100) |
                 (op == 3'b110);
  assign a_neg = a_sgn & rs1_data[XLEN-1];
  assign b_neg = b_sgn & rs2_data[XLEN-1];
  assign a_abs = a_neg ? (~rs1_data + 1'b1) : rs1_data;
  assign b_abs = b_neg ? (~rs2_data + 1'b1) : rs2_data;

  assign div0 = op[2] & (rs2_data == '0);
  assign ovf  = op[2] & ~op[0] & (&rs2_data) &
                (rs1_data == {1'b1, {(XLEN-1){1'b0}}});

  // div0: q=all ones, r=A; overflow: q=A (min int), r=0
  always_comb begin
    spec_res = '0;
    if (div0)
      spec_res = op[1] ? rs1_data : '1;
    else
      spec_res = op[1] ? '0 : rs1_data;
  end

  // one shift-add step: p = {acc_hi, multiplier}
  logic [XLEN:0]     add_s;
  logic [2*XLEN-1:0] mul_nx;

  assign add_s  = {1'b0, p[2*XLEN-1:XLEN]} +
                  (p[0] ? {1'b0, a_mag} : '0);
  assign mul_nx = {add_s, p[XLEN-1:1]};

  // one restoring step: p = {remainder, dividend/quotient}
  logic [XLEN:0]     sh;
  logic              ge;
  logic [XLEN-1:0]   r_sub;
  logic [2*XLEN-1:0] div_nx;

  assign sh     = {p[2*XLEN-1:XLEN], p[XLEN-1]};
  assign ge     = sh >= {1'b0, b_mag};
  // true difference is below b_mag, so XLEN bits suffice
  assign r_sub  = sh[XLEN-1:0] - b_mag;
  assign div_nx = {ge ? r_sub : sh[XLEN-1:0],
                   p[XLEN-2:0], ge};

  // sign fix on the final step's value
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo, rem;
  logic [XLEN-1:0]   calc_res;

  assign prod = neg_q ? (~mul_nx + 1'b1) : mul_nx;
  assign quo  = neg_q ? (~div_nx[XLEN-1:0] + 1'b1)
                      : div_nx[XLEN-1:0];
  assign rem  = rneg_q ? (~div_nx[2*XLEN-1:XLEN] + 1'b1)
                       : div_nx[2*XLEN-1:XLEN];

  always_comb begin
    calc_res = '0;
    unique case (op_q)
      3'b000:                 calc_res = prod[XLEN-1:0];
      3'b001, 3'b010, 3'b011: calc_res = prod[2*XLEN-1:XLEN];
      3'b100, 3'b101:         calc_res = quo;
      default:                calc_res = rem;
    endcase
  end

  always_comb begin
    if (rst)
      busy = start & ~flush;
    else
      busy = (start & ~flush & (state != CALC)) |
             (state == CALC);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      op_q         <= '0;
      rd_q         <= '0;
      a_mag        <= '0;
      b_mag        <= '0;
      p            <= '0;
      neg_q        <= 1'b0;
      rneg_q       <= 1'b0;
      result       <= '0;
      result_rd    <= '0;
      result_valid <= 1'b0;
    end else begin
      result_valid <= 1'b0;
      if (flush) begin
        state <= IDLE;
        cnt   <= '0;
      end else begin
        unique case (state)
          IDLE, DONE: begin
            if (start) begin
              op_q   <= op;
              rd_q   <= rd_addr;
              a_mag  <= a_abs;
              b_mag  <= b_abs;
              neg_q  <= a_neg ^ b_neg;
              rneg_q <= a_neg;
              cnt    <= '0;
              p      <= op[2] ? {{XLEN{1'b0}}, a_abs}
                              : {{XLEN{1'b0}}, b_abs};
              if (div0 | ovf) begin
                state        <= DONE;
                result       <= spec_res;
                result_rd    <= rd_addr;
                result_valid <= 1'b1;
              end else begin
                state <= CALC;
              end
            end else begin
              state <= IDLE;
            end
          end
          CALC: begin
            p   <= op_q[2] ? div_nx : mul_nx;
            cnt <= cnt + 1'b1;
            if (cnt == LAST) begin
              state        <= DONE;
              cnt          <= '0;
              result       <= calc_res;
              result_rd    <= rd_q;
              result_valid <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ex_muldiv.sv
// tb_ex_muldiv: randomized + directed self-checking bench for ex_muldiv.
// Reference model uses plain 64-bit arithmetic on the RV32M rules.
module tb_ex_muldiv;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  op;
  logic [31:0] rs1_data, rs2_data;
  logic [4:0]  rd_addr;
  logic        flush;
  logic        busy, result_valid;
  logic [31:0] result;
  logic [4:0]  result_rd;

  int checks = 0;
  int failures = 0;

  ex_muldiv #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op),
    .rs1_data(rs1_data), .rs2_data(rs2_data),
    .rd_addr(rd_addr), .flush(flush), .busy(busy),
    .result_valid(result_valid), .result(result),
    .result_rd(result_rd)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] model(
    input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ua, ub;
    logic [63:0] r;
    sa = longint'(signed'(a));
    sb = longint'(signed'(b));
    ua = longint'({32'b0, a});
    ub = longint'({32'b0, b});
    r = '0;
    case (o)
      3'd0: begin r = sa * sb; return r[31:0]; end
      3'd1: begin r = sa * sb; return r[63:32]; end
      3'd2: begin r = sa * ub; return r[63:32]; end
      3'd3: begin r = ua * ub; return r[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFFFFFF;
        r = sa / sb; return r[31:0];
      end
      3'd5: begin
        if (b == 0) return 32'hFFFFFFFF;
        r = ua / ub; return r[31:0];
      end
      3'd6: begin
        if (b == 0) return a;
        r = sa % sb; return r[31:0];
      end
      default: begin
        if (b == 0) return a;
        r = ua % ub; return r[31:0];
      end
    endcase
  endfunction

  function automatic int model_lat(
    input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    if (o[2] && b == 0) return 1;
    if (o[2] && !o[0] && a == 32'h80000000 && b == 32'hFFFFFFFF)
      return 1;
    return 33;
  endfunction

  // Issues one op in the current cycle (cycle 0), then watches for the
  // strobe; returns observed latency (-1 on timeout), result, rd and a
  // count of cycles where busy deviated from its expected level.
  task automatic issue(input logic [2:0] o, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] rd,
                       output int lat, output logic [31:0] res,
                       output logic [4:0] rdo, output int busy_bad);
    busy_bad = 0;
    lat = -1;
    res = '0;
    rdo = '0;
    @(negedge clk);
    start = 1'b1; op = o; rs1_data = a; rs2_data = b; rd_addr = rd;
    #1;
    if (busy !== 1'b1) busy_bad++;
    @(negedge clk);
    start = 1'b0;
    rs1_data = $urandom; rs2_data = $urandom; rd_addr = 5'($urandom);
    for (int c = 1; c <= 40; c++) begin
      #1;
      if (result_valid === 1'b1) begin
        lat = c; res = result; rdo = result_rd;
        if (busy !== 1'b0) busy_bad++;
        break;
      end
      if (busy !== 1'b1) busy_bad++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b1; flush = 1'b0; op = 3'b000;
    rs1_data = 32'd3; rs2_data = 32'd4; rd_addr = 5'd9;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL reset_busy got=%b want=1", busy);
    end
    checks++;
    if (result_valid !== 1'b0 || result !== 32'h0 || result_rd !== 5'd0) begin
      failures++;
      $display("FAIL reset_outputs got v=%b r=%h rd=%0d want 0/0/0",
               result_valid, result, result_rd);
    end
    start = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_idle_busy got=%b want=0", busy);
    end
  endtask

  task automatic test_directed;
    logic [2:0]  ops[6] = '{3'd0, 3'd3, 3'd2, 3'd4, 3'd6, 3'd7};
    logic [31:0] as[6] = '{32'h7, 32'hFFFFFFFF, 32'hFFFFFFFF,
                           32'hFFFFFFF9, 32'hFFFFFFF9, 32'h7};
    logic [31:0] bs[6] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'h2,
                           32'h2, 32'h2, 32'h0};
    logic [31:0] ex[6] = '{32'hFFFFFFEB, 32'hFFFFFFFE, 32'hFFFFFFFF,
                           32'hFFFFFFFD, 32'hFFFFFFFF, 32'h7};
    int          el[6] = '{33, 33, 33, 33, 33, 1};
    int lat, bb;
    logic [31:0] res;
    logic [4:0] rdo;
    for (int i = 0; i < 6; i++) begin
      issue(ops[i], as[i], bs[i], 5'(i + 5), lat, res, rdo, bb);
      checks++;
      if (lat !== el[i] || res !== ex[i] || rdo !== 5'(i + 5) || bb != 0) begin
        failures++;
        $display("FAIL directed_%0d got lat=%0d r=%h rd=%0d busybad=%0d want lat=%0d r=%h rd=%0d",
                 i, lat, res, rdo, bb, el[i], ex[i], i + 5);
      end
    end
    issue(3'd4, 32'h80000000, 32'hFFFFFFFF, 5'd30, lat, res, rdo, bb);
    checks++;
    if (lat !== 1 || res !== 32'h80000000 || rdo !== 5'd30) begin
      failures++;
      $display("FAIL div_ovf got lat=%0d r=%h rd=%0d want lat=1 r=80000000 rd=30",
               lat, res, rdo);
    end
    @(negedge clk);
    #1;
    checks++;
    if (result_valid !== 1'b0 || result !== 32'h80000000 || result_rd !== 5'd30) begin
      failures++;
      $display("FAIL hold got v=%b r=%h rd=%0d want 0/80000000/30",
               result_valid, result, result_rd);
    end
  endtask

  task automatic test_random;
    int lat, bb;
    logic [31:0] res, a, b;
    logic [4:0] rdo, rd;
    logic [2:0] o;
    for (int i = 0; i < 16; i++) begin
      o = 3'($urandom);
      a = $urandom;
      b = $urandom;
      if (i % 5 == 0) b = 32'h0;
      if (i % 7 == 3) b = 32'($urandom_range(1, 9));
      if (i == 11) begin a = 32'h80000000; b = 32'hFFFFFFFF; o = 3'd6; end
      rd = 5'($urandom);
      issue(o, a, b, rd, lat, res, rdo, bb);
      checks++;
      if (lat !== model_lat(o, a, b) || res !== model(o, a, b) ||
          rdo !== rd || bb != 0) begin
        failures++;
        $display("FAIL random_%0d op=%0d a=%h b=%h got lat=%0d r=%h rd=%0d busybad=%0d want lat=%0d r=%h rd=%0d",
                 i, o, a, b, lat, res, rdo, bb, model_lat(o, a, b),
                 model(o, a, b), rd);
      end
    end
  endtask

  task automatic test_flush;
    int seen, vcount;
    @(negedge clk);
    start = 1'b1; op = 3'd5; rs1_data = 32'd100; rs2_data = 32'd7;
    rd_addr = 5'd3;
    @(negedge clk);
    start = 1'b0;
    vcount = 0;
    for (int c = 1; c < 10; c++) begin
      #1; if (result_valid) vcount++;
      @(negedge clk);
    end
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || result_valid !== 1'b0 || vcount != 0) begin
      failures++;
      $display("FAIL flush_idle got busy=%b v=%b early=%0d want 0/0/0",
               busy, result_valid, vcount);
    end
    @(negedge clk);
    start = 1'b1; op = 3'd0; rs1_data = 32'd6; rs2_data = 32'd9;
    rd_addr = 5'd12;
    @(negedge clk);
    start = 1'b0;
    seen = -1;
    for (int c = 13; c <= 60; c++) begin
      #1;
      if (result_valid === 1'b1) begin seen = c; break; end
      @(negedge clk);
    end
    checks++;
    if (seen != 45 || result !== 32'd54 || result_rd !== 5'd12) begin
      failures++;
      $display("FAIL flush_restart got cyc=%0d r=%h rd=%0d want 45/36/12",
               seen, result, result_rd);
    end
    @(negedge clk);
    start = 1'b1; flush = 1'b1; op = 3'd0;
    #1;
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL flush_vs_start_busy got=%b want=0", busy);
    end
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || result_valid !== 1'b0) begin
      failures++;
      $display("FAIL flush_vs_start_state got busy=%b v=%b want 0/0",
               busy, result_valid);
    end
  endtask

  task automatic test_back_to_back;
    int seen1, seen2;
    logic [31:0] r1;
    logic [4:0] d1;
    logic b1;
    @(negedge clk);
    start = 1'b1; op = 3'd1; rs1_data = 32'h80000000;
    rs2_data = 32'h80000000; rd_addr = 5'd7;
    @(negedge clk);
    op = 3'd4; rs1_data = 32'hFFFFFF9C; rs2_data = 32'd7; rd_addr = 5'd8;
    seen1 = -1; r1 = '0; d1 = '0; b1 = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      #1;
      if (result_valid === 1'b1) begin
        seen1 = c; r1 = result; d1 = result_rd; b1 = busy; break;
      end
      @(negedge clk);
    end
    checks++;
    if (seen1 != 33 || r1 !== 32'h40000000 || d1 !== 5'd7 || b1 !== 1'b1) begin
      failures++;
      $display("FAIL b2b_first got cyc=%0d r=%h rd=%0d busy=%b want 33/40000000/7/1",
               seen1, r1, d1, b1);
    end
    @(negedge clk);
    start = 1'b0;
    seen2 = -1;
    for (int c = 1; c <= 40; c++) begin
      #1;
      if (result_valid === 1'b1) begin seen2 = c; break; end
      @(negedge clk);
    end
    checks++;
    if (seen2 != 33 || result !== model(3'd4, 32'hFFFFFF9C, 32'd7) ||
        result_rd !== 5'd8) begin
      failures++;
      $display("FAIL b2b_second got cyc=%0d r=%h rd=%0d want 33/%h/8",
               seen2, result, result_rd, model(3'd4, 32'hFFFFFF9C, 32'd7));
    end
  endtask

  task automatic test_rst_midcalc;
    int vcount;
    @(negedge clk);
    start = 1'b1; op = 3'd7; rs1_data = 32'd1000; rs2_data = 32'd33;
    rd_addr = 5'd21;
    @(negedge clk);
    start = 1'b0;
    repeat (14) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || result_valid !== 1'b0 || result !== 32'h0 ||
        result_rd !== 5'd0) begin
      failures++;
      $display("FAIL rst_midcalc got busy=%b v=%b r=%h rd=%0d want all 0",
               busy, result_valid, result, result_rd);
    end
    vcount = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk); #1;
      if (result_valid !== 1'b0 || busy !== 1'b0) vcount++;
    end
    checks++;
    if (vcount != 0) begin
      failures++;
      $display("FAIL rst_no_resume got=%0d bad cycles want=0", vcount);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_flush();
    test_back_to_back();
    test_rst_midcalc();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ex_muldiv.md
EX_MULDIV -- requirements
Module: ex_muldiv

Interface
REQ-001 Parameter: XLEN, default 32, operand/result width; all widths below are given for XLEN=32.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 start  input  1  EX stage holds a valid M-extension op this cycle.
REQ-005 op  input  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-006 rs1_data  input  32  operand A (EX_rs1_data after forwarding).
REQ-007 rs2_data  input  32  operand B.
REQ-008 rd_addr  input  5  destination register of the op.
REQ-009 flush  input  1  jump kill from ctrl; aborts the op in flight.
REQ-010 busy  output  1  hold request to ctrl; stalls the id_ex and if_id registers.
REQ-011 result_valid  output  1  one-cycle strobe, result is valid.
REQ-012 result  output  32  op result.
REQ-013 result_rd  output  5  rd_addr captured at accept.

Function
REQ-014 States SHALL be IDLE, CALC and DONE.
REQ-015 IDLE->CALC when start=1 and flush=0; op, operands and rd_addr are captured at that edge.
REQ-016 DONE->CALC on start=1 and flush=0 (back-to-back op); otherwise DONE->IDLE.
REQ-017 start SHALL be ignored while in CALC.
REQ-018 CALC: 32 iterations, one bit per cycle; a 5-bit counter runs 0..31, and CALC->DONE on the edge where the counter is 31.
REQ-019 Latency: start sampled in cycle 0 -> result_valid=1 in cycle 33 (the DONE cycle), for one cycle only.
REQ-020 busy = (start & ~flush & state!=CALC) | (state==CALC); busy SHALL be 0 in the DONE cycle so the pipeline advances and captures the result.
REQ-021 Multiply: shift-add on magnitudes gives a 64-bit product; sign fix is applied in DONE.
- MUL: product[31:0], low word independent of signedness.
- MULH: signed x signed, product[63:32].
- MULHSU: rs1 signed x rs2 unsigned, product[63:32].
- MULHU: unsigned x unsigned, product[63:32].
REQ-022 Divide: restoring division on magnitudes.
- Quotient sign = sign(A) xor sign(B), for signed ops only.
- Remainder sign = sign(A).
REQ-023 Divide by zero: quotient 0xFFFFFFFF, remainder = A. This path skips CALC (IDLE->DONE), so result_valid is in cycle 1.
REQ-024 Signed overflow (DIV/REM, A=0x80000000, B=0xFFFFFFFF): quotient 0x80000000, remainder 0. This path also skips CALC, result_valid in cycle 1.
REQ-025 flush=1 in any state -> IDLE at the next edge.
- result_valid is not asserted for the aborted op.
- flush dominates a simultaneous start.
REQ-026 result and result_rd SHALL hold their last value when result_valid=0.

Reset
REQ-027 rst=1 at an edge forces, regardless of state, including mid-CALC:
- state=IDLE, counter=0
- result=0x00000000, result_rd=0, result_valid=0
- all internal accumulators = 0
REQ-028 busy = start & ~flush while rst=1 is held; no op is accepted while rst=1.

Verification
REQ-029 MUL 7 x (-3) (0x00000007, 0xFFFFFFFD), rd=5 -> cycle 33: result 0xFFFFFFEB, result_rd 5; busy high cycles 0-32.
REQ-030 MULHU 0xFFFFFFFF x 0xFFFFFFFF -> result 0xFFFFFFFE; MULHSU 0xFFFFFFFF x 0x00000002 -> result 0xFFFFFFFF.
REQ-031 DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; REMU 7/0 -> 7 in cycle 1; DIV 0x80000000/-1 -> 0x80000000 in cycle 1.
REQ-032 flush at cycle 10 of a DIVU -> state IDLE at cycle 11, busy=0, no result_valid; a new start at cycle 12 completes at cycle 45.
REQ-033 Back-to-back: start held through the DONE cycle of op 1 -> op 2 accepted there, its result_valid 33 cycles later; rst=1 mid-CALC -> all outputs 0 at the next cycle.
